// File: rtl/gain_interp_pkg.sv
// Shared constants, band table and helpers for the per-bin gain interpolator.
package gain_interp_pkg;

    localparam int GAIN_W      = 16;
    localparam int NB_BANDS    = 22;
    localparam int FRAME_BINS  = 481;
    localparam int INTERP_BINS = 400;
    localparam int BIN_W       = 9;
    localparam int BAND_W      = 5;
    localparam int SPAN_W      = 7;
    localparam int SUM_W       = 22;
    localparam int RECIP_W     = 17;
    localparam int PROD_W      = 40;

    localparam logic [GAIN_W-1:0] GAIN_ONE = 16'h8000;

    // Band edges in bins; band b covers [edge[b], edge[b+1]).
    localparam logic [BIN_W-1:0] BAND_EDGE [NB_BANDS] = '{
        9'd0,   9'd4,   9'd8,   9'd12,  9'd16,  9'd20,  9'd24,  9'd28,
        9'd32,  9'd40,  9'd48,  9'd56,  9'd64,  9'd80,  9'd96,  9'd112,
        9'd136, 9'd160, 9'd192, 9'd240, 9'd312, 9'd400
    };

    // round(2^18 / span) for each interpolating band.
    localparam logic [RECIP_W-1:0] BAND_RECIP [NB_BANDS-1] = '{
        17'd65536, 17'd65536, 17'd65536, 17'd65536,
        17'd65536, 17'd65536, 17'd65536, 17'd65536,
        17'd32768, 17'd32768, 17'd32768, 17'd32768,
        17'd16384, 17'd16384, 17'd16384,
        17'd10923, 17'd10923,
        17'd8192,  17'd5461,  17'd3641,  17'd2979
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INTERP = 2'd1,
        ZERO   = 2'd2
    } state_t;

    function automatic logic [SPAN_W-1:0] band_span(input logic [BAND_W-1:0] b);
        return SPAN_W'(BAND_EDGE[b + 5'd1] - BAND_EDGE[b]);
    endfunction

    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g);
        return (g > GAIN_ONE) ? GAIN_ONE : g;
    endfunction

endpackage

// File: rtl/gain_interp_if.sv
// Frame-in / bin-out handshake bundle of the gain interpolator.
interface gain_interp_if;
    import gain_interp_pkg::*;

    logic                         gains_valid;
    logic                         gains_ready;
    logic [NB_BANDS*GAIN_W-1:0]   gains_in;
    logic                         bin_valid;
    logic                         bin_ready;
    logic [BIN_W-1:0]             bin_idx;
    logic [GAIN_W-1:0]            bin_gain;
    logic                         frame_done;

    modport slave (
        input  gains_valid, gains_in, bin_ready,
        output gains_ready, bin_valid, bin_idx, bin_gain, frame_done
    );

    modport master (
        output gains_valid, gains_in, bin_ready,
        input  gains_ready, bin_valid, bin_idx, bin_gain, frame_done
    );

endinterface

// File: rtl/gain_interp_mac.sv
// Weighted-sum register stage followed by reciprocal multiply, round and saturate.
// The output is a pure function of the registered sum/reciprocal pair.
module gain_interp_mac
    import gain_interp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              zero,
    input  logic [BAND_W-1:0] band,
    input  logic [SPAN_W-1:0] j,
    input  logic [GAIN_W-1:0] g_lo,
    input  logic [GAIN_W-1:0] g_hi,
    output logic [GAIN_W-1:0] gain
);

    logic [SPAN_W-1:0]  span_s;
    logic [SPAN_W-1:0]  w_lo_s;
    logic [SUM_W-1:0]   sum_s;
    logic [SUM_W-1:0]   sum_r;
    logic [RECIP_W-1:0] recip_r;
    logic [PROD_W-1:0]  prod_s;
    logic [PROD_W-1:0]  rnd_s;
    logic [SUM_W-1:0]   q_s;

    // Weighted sum of the two band-edge gains for the current bin.
    always_comb begin
        span_s = band_span(band);
        w_lo_s = span_s - j;
        sum_s  = {{(SUM_W-GAIN_W){1'b0}}, g_lo} * {{(SUM_W-SPAN_W){1'b0}}, w_lo_s}
               + {{(SUM_W-GAIN_W){1'b0}}, g_hi} * {{(SUM_W-SPAN_W){1'b0}}, j};
    end

    // Pipeline register; zero bins carry a zero sum so the product is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= {SUM_W{1'b0}};
            recip_r <= {RECIP_W{1'b0}};
        end else if (en) begin
            if (zero) begin
                sum_r   <= {SUM_W{1'b0}};
                recip_r <= {RECIP_W{1'b0}};
            end else begin
                sum_r   <= sum_s;
                recip_r <= BAND_RECIP[band];
            end
        end
    end

    // Divide by span via reciprocal, round half up, saturate to 1.0.
    always_comb begin
        prod_s = {{(PROD_W-SUM_W){1'b0}}, sum_r} * {{(PROD_W-RECIP_W){1'b0}}, recip_r};
        rnd_s  = prod_s + 40'd131072;
        q_s    = SUM_W'(rnd_s >> 6'd18);
        gain   = (q_s > 22'd32768) ? GAIN_ONE : q_s[GAIN_W-1:0];
    end

endmodule

// File: rtl/gain_interp.sv
// Expands 22 band gains into 481 bin gains streamed over valid/ready.
// Optional input clamping of band gains above 1.0: define GAIN_INTERP_CLAMP_EN.
module gain_interp
    import gain_interp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    gain_interp_if.slave  bus
);

    state_t             state_r, state_s;
    logic [BAND_W-1:0]  band_r, band_s, band_nx_s;
    logic [SPAN_W-1:0]  j_r, j_s, span_s;
    logic [BIN_W-1:0]   gen_idx_r, gen_idx_s;
    logic [BIN_W-1:0]   bin_idx_r;
    logic               bin_valid_r;
    logic               gains_ready_r;
    logic [GAIN_W-1:0]  gain_r [NB_BANDS];
    logic [GAIN_W-1:0]  bin_gain_s;
    logic               adv_s, accept_s, done_s, gen_valid_s;

    function automatic logic [GAIN_W-1:0] capture_gain(input logic [GAIN_W-1:0] g);
`ifdef GAIN_INTERP_CLAMP_EN
        return clamp_gain(g);
`else
        return g;
`endif
    endfunction

    // Whole pipeline advances only when the output slot is empty or being taken.
    assign adv_s       = !bin_valid_r || bus.bin_ready;
    assign accept_s    = bus.gains_valid && gains_ready_r;
    assign done_s      = bin_valid_r && bus.bin_ready && (bin_idx_r == BIN_W'(FRAME_BINS-1));
    assign gen_valid_s = (state_r == INTERP) ||
                         ((state_r == ZERO) && (gen_idx_r < BIN_W'(FRAME_BINS)));
    assign band_nx_s   = band_r + 5'd1;
    assign span_s      = band_span(band_r);

    // Next-state and bin-generator counter logic.
    always_comb begin
        state_s   = state_r;
        band_s    = band_r;
        j_s       = j_r;
        gen_idx_s = gen_idx_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = INTERP;
                    band_s    = {BAND_W{1'b0}};
                    j_s       = {SPAN_W{1'b0}};
                    gen_idx_s = {BIN_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            INTERP: begin
                if (adv_s) begin
                    gen_idx_s = gen_idx_r + 9'd1;
                    if (j_r == span_s - 7'd1) begin
                        j_s = {SPAN_W{1'b0}};
                        if (band_r == BAND_W'(NB_BANDS-2)) begin
                            state_s = ZERO;
                        end else begin
                            band_s = band_nx_s;
                        end
                    end else begin
                        j_s = j_r + 7'd1;
                    end
                end else begin
                    state_s = INTERP;
                end
            end
            ZERO: begin
                if (done_s) begin
                    state_s = IDLE;
                end else if (adv_s && gen_valid_s) begin
                    gen_idx_s = gen_idx_r + 9'd1;
                end else begin
                    state_s = ZERO;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and frame-acceptance flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            band_r        <= {BAND_W{1'b0}};
            j_r           <= {SPAN_W{1'b0}};
            gen_idx_r     <= {BIN_W{1'b0}};
            gains_ready_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            band_r        <= band_s;
            j_r           <= j_s;
            gen_idx_r     <= gen_idx_s;
            gains_ready_r <= (state_s == IDLE);
        end
    end

    // Band gain register file, loaded once per accepted frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NB_BANDS; k++) begin
                gain_r[k] <= {GAIN_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int k = 0; k < NB_BANDS; k++) begin
                gain_r[k] <= capture_gain(bus.gains_in[k*GAIN_W +: GAIN_W]);
            end
        end
    end

    // Output valid/index register, aligned with the MAC pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_valid_r <= 1'b0;
            bin_idx_r   <= {BIN_W{1'b0}};
        end else if (adv_s) begin
            bin_valid_r <= gen_valid_s;
            if (gen_valid_s) begin
                bin_idx_r <= gen_idx_r;
            end
        end
    end

    gain_interp_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv_s),
        .zero  (state_r != INTERP),
        .band  (band_r),
        .j     (j_r),
        .g_lo  (gain_r[band_r]),
        .g_hi  (gain_r[band_nx_s]),
        .gain  (bin_gain_s)
    );

    assign bus.gains_ready = gains_ready_r;
    assign bus.bin_valid   = bin_valid_r;
    assign bus.bin_idx     = bin_idx_r;
    assign bus.bin_gain    = bin_gain_s;
    assign bus.frame_done  = done_s;

endmodule
